// File: rtl/frame_sync.sv
// Bit-level frame synchronizer: hunts for a preamble (with bounded bit errors), then forwards a fixed-length payload.
// Optional FRAME_SYNC_INVERT_EN also accepts the inverted preamble and inverts that frame's payload (BPSK phase ambiguity).
module frame_sync #(
    parameter int                         PREAMBLE_LENGTH = 16,
    parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE        = 16'hF3A2,
    parameter int                         PAYLOAD_BITS    = 72,
    parameter int                         MAX_ERRORS      = 1,
    parameter int                         TIMEOUT         = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    output logic clear,
    output logic read,
    output logic data_stream,
    output logic locked,
    output logic frame_done,
    output logic abort
);
    localparam int L     = PREAMBLE_LENGTH;
    localparam int POP_W = $clog2(L + 1);
    localparam int CNT_W = $clog2(PAYLOAD_BITS + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [POP_W-1:0] ERR_LIM   = POP_W'(MAX_ERRORS);
    localparam logic [POP_W-1:0] FILL_LAST = POP_W'(L - 1);
    localparam logic [POP_W-1:0] FILL_FULL = POP_W'(L);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic {S_HUNT, S_PAYLOAD} state_t;

    function automatic logic [POP_W-1:0] popcount(input logic [L-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < L; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction

    state_t           r_state;
    logic [L-2:0]     r_shift;   // only the last L-1 bits are kept; the incoming bit completes the window
    logic [POP_W-1:0] r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0]  r_wdog;
    logic             r_clear, r_read, r_data, r_locked, r_done, r_abort;

    state_t           w_state_nxt;
    logic [L-1:0]     w_next_shift;
    logic [L-2:0]     w_shift_nxt;
    logic [POP_W-1:0] w_fill_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic             w_clear_nxt, w_read_nxt, w_data_nxt, w_locked_nxt, w_done_nxt, w_abort_nxt;
    logic             w_armed, w_hit_true, w_hit_any, w_payload_bit;

`ifdef FRAME_SYNC_INVERT_EN
    logic r_invert;
    logic w_invert_nxt, w_hit_inv;
`endif

    always_comb begin
        w_next_shift  = {r_shift, bit_in};
        w_armed       = (r_fill >= FILL_LAST);
        w_hit_true    = w_armed && (popcount(w_next_shift ^ PREAMBLE) <= ERR_LIM);
`ifdef FRAME_SYNC_INVERT_EN
        w_hit_inv     = w_armed && (popcount(w_next_shift ^ ~PREAMBLE) <= ERR_LIM);
        w_hit_any     = w_hit_true || w_hit_inv;
        w_payload_bit = bit_in ^ r_invert;
        w_invert_nxt  = r_invert;
`else
        w_hit_any     = w_hit_true;
        w_payload_bit = bit_in;
`endif
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_fill_nxt   = r_fill;
        w_cnt_nxt    = r_cnt;
        w_wdog_nxt   = r_wdog;
        w_clear_nxt  = 1'b0;
        w_read_nxt   = 1'b0;
        w_data_nxt   = r_data;
        w_locked_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_abort_nxt  = 1'b0;

        if (r_state == S_HUNT) begin
            if (bit_valid) begin
                if (w_hit_any) begin
                    w_state_nxt  = S_PAYLOAD;
                    w_clear_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_wdog_nxt   = '0;
                    w_shift_nxt  = '0;
                    w_fill_nxt   = '0;
`ifdef FRAME_SYNC_INVERT_EN
                    w_invert_nxt = !w_hit_true;
`endif
                end else begin
                    w_shift_nxt = w_next_shift[L-2:0];
                    if (r_fill != FILL_FULL) w_fill_nxt = r_fill + POP_W'(1);
                end
            end
        end else begin
            w_locked_nxt = 1'b1;
            if (bit_valid) begin
                w_read_nxt = 1'b1;
                w_data_nxt = w_payload_bit;
                w_wdog_nxt = '0;
                if (r_cnt == CNT_LAST) begin
                    // Last payload bit: hand back to HUNT with a fresh, empty window
                    w_state_nxt  = S_HUNT;
                    w_done_nxt   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_shift_nxt  = '0;
                    w_fill_nxt   = '0;
`ifdef FRAME_SYNC_INVERT_EN
                    w_invert_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else if (r_wdog == WD_LAST) begin
                // Stalled frame: clear tells the buffer to drop the partial payload
                w_state_nxt  = S_HUNT;
                w_abort_nxt  = 1'b1;
                w_clear_nxt  = 1'b1;
                w_locked_nxt = 1'b0;
                w_wdog_nxt   = '0;
                w_cnt_nxt    = '0;
                w_shift_nxt  = '0;
                w_fill_nxt   = '0;
`ifdef FRAME_SYNC_INVERT_EN
                w_invert_nxt = 1'b0;
`endif
            end else begin
                w_wdog_nxt = r_wdog + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_HUNT;
            r_shift  <= '0;
            r_fill   <= '0;
            r_cnt    <= '0;
            r_wdog   <= '0;
            r_clear  <= 1'b0;
            r_read   <= 1'b0;
            r_data   <= 1'b0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
`ifdef FRAME_SYNC_INVERT_EN
            r_invert <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_fill   <= w_fill_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wdog   <= w_wdog_nxt;
            r_clear  <= w_clear_nxt;
            r_read   <= w_read_nxt;
            r_data   <= w_data_nxt;
            r_locked <= w_locked_nxt;
            r_done   <= w_done_nxt;
            r_abort  <= w_abort_nxt;
`ifdef FRAME_SYNC_INVERT_EN
            r_invert <= w_invert_nxt;
`endif
        end
    end

    assign clear       = r_clear;
    assign read        = r_read;
    assign data_stream = r_data;
    assign locked      = r_locked;
    assign frame_done  = r_done;
    assign abort       = r_abort;
endmodule

// File: doc/frame_sync.md
# frame_sync

Bit-level frame synchronizer between the BPSK demodulator and the receiver packet buffer. It hunts the demodulated bit stream for the preamble, tolerating a bounded number of bit errors. On a match it issues one buffer-clear pulse. It then forwards exactly `PAYLOAD_BITS` bits as single-cycle read strobes with data, and returns to hunting. A stalled frame is aborted by a watchdog.

## Interface
- `PREAMBLE_LENGTH`, 16: preamble length in bits (2..64).
- `PREAMBLE`, 16'hF3A2: preamble pattern; MSB is the first bit on air.
- `PAYLOAD_BITS`, 72: number of bits forwarded per frame after the preamble (1..4095).
- `MAX_ERRORS`, 1: maximum Hamming distance accepted as a match (0..PREAMBLE_LENGTH/4).
- `TIMEOUT`, 4096: clock cycles without `bit_valid` in PAYLOAD before an abort (≥2).
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `bit_in`, input, 1: demodulated bit decision; sampled only when `bit_valid` is high.
- `bit_valid`, input, 1: single-cycle strobe, one per recovered bit.
- `clear`, output, 1: one-cycle pulse that empties the downstream buffer.
- `read`, output, 1: one-cycle strobe; `data_stream` holds a payload bit.
- `data_stream`, output, 1: payload bit, registered.
- `locked`, output, 1: high while in PAYLOAD.
- `frame_done`, output, 1: one-cycle pulse after the last payload bit is forwarded.
- `abort`, output, 1: one-cycle pulse on watchdog expiry.

## Operation
- Reset, asynchronous: state=HUNT; shift register, bit counter and watchdog are cleared. All outputs are 0: `clear`, `read`, `data_stream`, `locked`, `frame_done`, `abort`.
- HUNT:
  - On `bit_valid`, the next shift value is `{shift[L-2:0], bit_in}`.
  - The block computes the popcount of (next shift value XOR `PREAMBLE`), with width $clog2(L+1).
  - If the popcount is ≤`MAX_ERRORS`, the block goes to PAYLOAD. Otherwise the shift register takes the next value.
  - While fewer than L bits have been shifted since entering HUNT, matches are suppressed; a fill counter saturates at L.
- Entering PAYLOAD: `clear`=1 for exactly one cycle, `locked`=1, and the bit counter and watchdog are set to 0.
- PAYLOAD:
  - Each `bit_valid` gives `read`=1 and `data_stream`=`bit_in`, both registered, and increments the counter.
  - The watchdog resets on every `bit_valid` and otherwise increments.
- Completion: the strobe carrying bit number `PAYLOAD_BITS` moves the state to HUNT. On the same edge `frame_done`=1 and `locked`=0. The shift register and fill counter clear, so payload bits never match a preamble.
- Watchdog: when it reaches `TIMEOUT`-1 without a strobe, the block goes to HUNT. It pulses `abort` and `clear` together for one cycle. Partial payload already forwarded is discarded downstream by that `clear`.
- `read` is never asserted in HUNT. `clear` and `read` are never high in the same cycle.

## Timing
- Outputs are registered: each output reflects the input strobe on the next rising edge.
- Preamble-completing strobe at edge N: `clear`=1 during cycle N+1. That strobe is not forwarded.
- `bit_valid` during the `clear` cycle is the first payload bit; its `read` appears in cycle N+2.
- Back-to-back `bit_valid` on every cycle is supported without loss.
- Last payload strobe at edge M: `read` and `frame_done` are both high in cycle M+1. A `bit_valid` in cycle M+1 is the first HUNT bit.
- Reset mid-frame takes effect immediately. No `clear`, `frame_done` or `abort` is generated by reset itself.

## Configuration
- `FRAME_SYNC_INVERT_EN` defined: HUNT also matches the bitwise inverse of `PREAMBLE`, using the same error tolerance. This covers the 180° BPSK phase ambiguity.
  - An inverted match latches the `invert` flag, and all payload bits are output as `~bit_in` for that frame.
  - A true match takes priority if both satisfy the threshold.
  - `invert` clears on return to HUNT and on reset.
- Undefined: only the true pattern matches, and there is no inversion logic.

## Test plan
- Clean frame: send 0xF3A2 MSB-first, then 72 bits 0xC3 repeated; `bit_valid` every 4 cycles. Require:
  - `clear` exactly once.
  - 72 `read` pulses carrying the payload bit-for-bit.
  - `frame_done` together with read #72.
  - `locked` deasserted afterwards.
- Error tolerance: preamble with 1 bit flipped must lock. With 2 bits flipped there must be no `clear` and no `read`.
- Back-to-back: `bit_valid` held high continuously. Require `clear` one cycle before the first `read`, 72 consecutive `read` cycles, and no dropped bits.
- Timeout: lock, send 10 payload bits, then stop strobes for 4096 cycles. Require `abort` and `clear` together at the expiry cycle and state HUNT. A subsequent clean frame must lock normally.
- Reset mid-payload: assert `reset` after payload bit 30. All outputs must be 0 asynchronously, with no spurious pulses. A payload containing the 0xF3A2 pattern must not relock until after `frame_done`.
- With `FRAME_SYNC_INVERT_EN`: send 0x0C5D as the preamble, then payload 0x3C. Require lock and `data_stream` equal to 0xC3. Without the macro, the same stimulus must give no lock.
